// File: rtl/rps_reveal_mux.sv
// rtl/rps_reveal_mux.sv - debounced dual-GO hand latch with multiplexed active-low 7-segment reveal
// Optional feature macro: RPS_WINNER_EN (shows the round outcome on the last digit)
module rps_reveal_mux #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REVEAL_CYC   = 100000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*NUM_PLAYERS-1:0] hand,
    input  logic                     go1,
    input  logic                     go2,
    output logic [7:0]               sseg,
    output logic [NUM_DIGITS-1:0]    an,
    output logic                     disp
);

    localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int DVW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int IW  = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
    localparam int TW  = (REVEAL_CYC   > 1) ? $clog2(REVEAL_CYC)   : 1;

    localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [DVW-1:0] DIV_LAST    = DVW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST    = IW'(NUM_DIGITS - 1);
    localparam logic [TW-1:0]  REVEAL_LOAD = TW'(REVEAL_CYC - 1);

    localparam logic [7:0] SEG_ROCK     = 8'b10101111;
    localparam logic [7:0] SEG_PAPER    = 8'b10001100;
    localparam logic [7:0] SEG_SCISSORS = 8'b10010010;
    localparam logic [7:0] SEG_BLANK    = 8'b11111111;
    localparam logic [7:0] SEG_DASH     = 8'b10111111;

    typedef enum logic [1:0] {IDLE, REVEAL, WAIT_REL} state_t;

    function automatic logic [7:0] hand_seg(input logic [1:0] h);
        case (h)
            2'b00:   hand_seg = SEG_ROCK;
            2'b01:   hand_seg = SEG_PAPER;
            2'b10:   hand_seg = SEG_SCISSORS;
            default: hand_seg = SEG_BLANK;
        endcase
    endfunction

    logic [1:0]          go_raw;
    logic [1:0]          sync1, sync2, db;
    logic [1:0][DBW-1:0] db_cnt;
    logic                go_both, go_both_q, go_rise;
    logic                hands_valid;
    state_t              state;
    logic [TW-1:0]       timer;
    logic [2*NUM_PLAYERS-1:0] latched;
    logic [DVW-1:0]      div;
    logic [IW-1:0]       idx;
    logic [NUM_DIGITS-1:0] an_next;
    logic [7:0]          seg_next;

    assign go_raw  = {go2, go1};
    assign go_both = db[0] & db[1];
    assign go_rise = go_both & ~go_both_q;

    // Synchronise both buttons and accept a new level only after it has held steady
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= go_raw;
            sync2 <= sync1;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == db[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    db[b]     <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + DBW'(1);
                end
            end
        end
    end

    // A round may only start when every player has picked a real shape
    always_comb begin
        hands_valid = 1'b1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (hand[2*p +: 2] == 2'b11) hands_valid = 1'b0;
        end
    end

`ifdef RPS_WINNER_EN
    logic [7:0] win_seg, win_next;

    // Outcome from the set of shapes present: exactly two distinct shapes give a winner
    always_comb begin
        logic has_r, has_p, has_s;
        has_r = 1'b0;
        has_p = 1'b0;
        has_s = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (hand[2*p +: 2] == 2'b00) has_r = 1'b1;
            if (hand[2*p +: 2] == 2'b01) has_p = 1'b1;
            if (hand[2*p +: 2] == 2'b10) has_s = 1'b1;
        end
        if (has_r && has_s && !has_p)      win_next = SEG_ROCK;
        else if (has_s && has_p && !has_r) win_next = SEG_SCISSORS;
        else if (has_p && has_r && !has_s) win_next = SEG_PAPER;
        else                               win_next = SEG_DASH;
    end
`endif

    // Round control: latch on a GO-both edge, hold for the reveal time, then wait for release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            go_both_q <= 1'b0;
            latched   <= '1;
`ifdef RPS_WINNER_EN
            win_seg   <= SEG_BLANK;
`endif
        end else begin
            go_both_q <= go_both;
            case (state)
                IDLE: begin
                    if (go_rise && hands_valid) begin
                        latched <= hand;
                        timer   <= REVEAL_LOAD;
                        state   <= REVEAL;
`ifdef RPS_WINNER_EN
                        win_seg <= win_next;
`endif
                    end
                end
                REVEAL: begin
                    if (timer == '0) state <= WAIT_REL;
                    else             timer <= timer - TW'(1);
                end
                WAIT_REL: begin
                    if (!go_both) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Refresh divider and digit scan, running in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            div <= div + DVW'(1);
        end
    end

    // Anode and segment pattern for the digit currently selected
    always_comb begin
        an_next  = '1;
        seg_next = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) an_next[i] = 1'b0;
        end
        if (state != IDLE) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (idx == IW'(p)) seg_next = hand_seg(latched[2*p +: 2]);
            end
`ifdef RPS_WINNER_EN
            if (idx == IDX_LAST) seg_next = win_seg;
`endif
        end
    end

    // Registered outputs so the board pins never see combinational glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sseg <= SEG_BLANK;
            an   <= '1;
            disp <= 1'b1;
        end else begin
            sseg <= seg_next;
            an   <= an_next;
            disp <= (state == IDLE);
        end
    end

endmodule

// File: tb/tb_rps_reveal_mux.sv
// tb/tb_rps_reveal_mux.sv - randomized self-checking bench for rps_reveal_mux
module tb_rps_reveal_mux;

    localparam int NP = 2;
    localparam int ND = 4;
    localparam int RD = 2;
    localparam int DC = 4;
    localparam int RC = 10;

    localparam logic [7:0] S_ROCK  = 8'b10101111;
    localparam logic [7:0] S_PAPER = 8'b10001100;
    localparam logic [7:0] S_SCIS  = 8'b10010010;
    localparam logic [7:0] S_BLANK = 8'b11111111;
    localparam logic [7:0] S_DASH  = 8'b10111111;

    // Press-to-display and release-to-idle latencies in ticks, from the timing rules
    localparam int SHOW_AT  = DC + 2 + 1 + 1;
    localparam int IDLE_AT  = DC + 2 + 1 + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  hand = 4'b0000;
    logic        go1 = 1'b0;
    logic        go2 = 1'b0;
    logic [7:0]  sseg;
    logic [3:0]  an;
    logic        disp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    rps_reveal_mux #(
        .NUM_PLAYERS (NP),
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .DEBOUNCE_CYC(DC),
        .REVEAL_CYC  (RC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hand (hand),
        .go1  (go1),
        .go2  (go2),
        .sseg (sseg),
        .an   (an),
        .disp (disp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int cur_digit();
        return ((cyc - 1) / RD) % ND;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] a;
        a = 4'b1111;
        a[cur_digit()] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] shape_seg(input logic [1:0] h);
        case (h)
            2'd0:    return S_ROCK;
            2'd1:    return S_PAPER;
            2'd2:    return S_SCIS;
            default: return S_BLANK;
        endcase
    endfunction

    function automatic bit beats(input logic [1:0] x, input logic [1:0] y);
        return (x == 2'd0 && y == 2'd2) || (x == 2'd2 && y == 2'd1) || (x == 2'd1 && y == 2'd0);
    endfunction

    function automatic logic [7:0] outcome(input logic [1:0] a, input logic [1:0] b);
        if (a == b) return S_DASH;
        return beats(a, b) ? shape_seg(a) : shape_seg(b);
    endfunction

    function automatic logic [7:0] exp_sseg(input bit shown, input logic [1:0] h0, input logic [1:0] h1);
        int d;
        d = cur_digit();
        if (!shown) return S_BLANK;
        if (d == 0) return shape_seg(h0);
        if (d == 1) return shape_seg(h1);
`ifdef RPS_WINNER_EN
        if (d == ND - 1) return outcome(h0, h1);
`endif
        return S_BLANK;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            checks++;
            if (an !== exp_an()) begin
                failures++;
                $display("FAIL reset_scan t=%0d an got=%b want=%b", t, an, exp_an());
            end
            checks++;
            if (sseg !== S_BLANK || disp !== 1'b1) begin
                failures++;
                $display("FAIL reset_idle t=%0d sseg/disp got=%h/%b want=%h/1", t, sseg, disp, S_BLANK);
            end
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (sseg !== 8'hFF || an !== 4'b1111 || disp !== 1'b1) begin
            failures++;
            $display("FAIL reset_async sseg/an/disp got=%h/%b/%b want=ff/1111/1", sseg, an, disp);
        end
        #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++;
            if (an !== exp_an()) begin
                failures++;
                $display("FAIL reset_rescan t=%0d an got=%b want=%b", t, an, exp_an());
            end
        end
    endtask

    task automatic test_bounce();
        int w;
        int g;
        hand = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            w = $urandom_range(1, 3);
            g = $urandom_range(1, 2);
            go1 = 1'b1;
            go2 = 1'b1;
            repeat (w) begin
                tick();
                checks++;
                if (disp !== 1'b1) begin
                    failures++;
                    $display("FAIL bounce_glitch k=%0d disp got=%b want=1", k, disp);
                end
            end
            go1 = 1'b0;
            go2 = 1'b0;
            repeat (g) tick();
        end
        go1 = 1'b1;
        go2 = 1'b1;
        for (int t = 1; t <= SHOW_AT; t++) begin
            tick();
            checks++;
            if (disp !== (t < SHOW_AT)) begin
                failures++;
                $display("FAIL bounce_latency t=%0d disp got=%b want=%b", t, disp, (t < SHOW_AT));
            end
        end
        go1 = 1'b0;
        go2 = 1'b0;
        for (int t = SHOW_AT + 1; t <= SHOW_AT + RC + 2; t++) begin
            tick();
            checks++;
            if (disp !== (t > SHOW_AT + RC)) begin
                failures++;
                $display("FAIL bounce_reveal_len t=%0d disp got=%b want=%b", t, disp, (t > SHOW_AT + RC));
            end
        end
    endtask

    task automatic test_reveal();
        logic [1:0] h0, h1;
        int chg;
        bit shown;
        for (int r = 0; r < 4; r++) begin
            h0 = 2'($urandom_range(0, 2));
            h1 = 2'($urandom_range(0, 2));
            if (r == 0) begin
                h0 = 2'd0;
                h1 = 2'd1;
            end
            hand = {h1, h0};
            chg = $urandom_range(SHOW_AT + 1, SHOW_AT + RC - 1);
            go1 = 1'b1;
            go2 = 1'b1;
            for (int t = 1; t <= 30; t++) begin
                if (t == chg) hand = (r == 0) ? 4'b1010 : 4'($urandom);
                tick();
                shown = (t >= SHOW_AT);
                checks++;
                if (disp !== !shown) begin
                    failures++;
                    $display("FAIL reveal_disp r=%0d t=%0d got=%b want=%b", r, t, disp, !shown);
                end
                checks++;
                if (sseg !== exp_sseg(shown, h0, h1) || an !== exp_an()) begin
                    failures++;
                    $display("FAIL reveal_seg r=%0d t=%0d sseg/an got=%h/%b want=%h/%b",
                             r, t, sseg, an, exp_sseg(shown, h0, h1), exp_an());
                end
            end
            go1 = 1'b0;
            go2 = 1'b0;
            for (int t = 1; t <= IDLE_AT; t++) begin
                tick();
                shown = (t < IDLE_AT);
                checks++;
                if (disp !== !shown || sseg !== exp_sseg(shown, h0, h1)) begin
                    failures++;
                    $display("FAIL release r=%0d t=%0d sseg/disp got=%h/%b want=%h/%b",
                             r, t, sseg, disp, exp_sseg(shown, h0, h1), !shown);
                end
            end
        end
    endtask

    task automatic test_invalid();
        int k;
        k = $urandom_range(0, 2);
        case (k)
            0:       hand = 4'b1100;
            1:       hand = 4'b0011;
            default: hand = 4'b1111;
        endcase
        go1 = 1'b1;
        go2 = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            if (t == 14) hand = 4'b0110;
            tick();
            checks++;
            if (disp !== 1'b1 || sseg !== S_BLANK) begin
                failures++;
                $display("FAIL invalid_hand k=%0d t=%0d sseg/disp got=%h/%b want=ff/1", k, t, sseg, disp);
            end
        end
        go1 = 1'b0;
        go2 = 1'b0;
        repeat (IDLE_AT) tick();
    endtask

    task automatic test_one_button_release();
        logic [1:0] h0, h1;
        int rel;
        bit shown;
        for (int r = 0; r < 2; r++) begin
            h0 = 2'($urandom_range(0, 2));
            h1 = 2'($urandom_range(0, 2));
            hand = {h1, h0};
            rel = $urandom_range(SHOW_AT, SHOW_AT + 2);
            go1 = 1'b1;
            go2 = 1'b1;
            for (int t = 1; t <= SHOW_AT + RC + 4; t++) begin
                tick();
                if (t == rel) begin
                    if (r == 0) go1 = 1'b0;
                    else        go2 = 1'b0;
                end
                shown = (t >= SHOW_AT) && (t <= SHOW_AT + RC);
                checks++;
                if (disp !== !shown || sseg !== exp_sseg(shown, h0, h1)) begin
                    failures++;
                    $display("FAIL one_release r=%0d t=%0d sseg/disp got=%h/%b want=%h/%b",
                             r, t, sseg, disp, exp_sseg(shown, h0, h1), !shown);
                end
            end
            go1 = 1'b0;
            go2 = 1'b0;
            repeat (IDLE_AT) tick();
        end
    endtask

`ifdef RPS_WINNER_EN
    task automatic test_winner();
        logic [3:0]  hands [2];
        logic [7:0]  want  [2];
        hands[0] = 4'b1000;
        want[0]  = S_ROCK;
        hands[1] = 4'b0000;
        want[1]  = S_DASH;
        for (int r = 0; r < 2; r++) begin
            hand = hands[r];
            go1 = 1'b1;
            go2 = 1'b1;
            for (int t = 1; t <= 24; t++) begin
                tick();
                if (cur_digit() == ND - 1) begin
                    checks++;
                    if (sseg !== ((t >= SHOW_AT) ? want[r] : S_BLANK)) begin
                        failures++;
                        $display("FAIL winner r=%0d t=%0d sseg got=%h want=%h",
                                 r, t, sseg, (t >= SHOW_AT) ? want[r] : S_BLANK);
                    end
                end
            end
            go1 = 1'b0;
            go2 = 1'b0;
            repeat (IDLE_AT) tick();
        end
    endtask
`endif

    task automatic test_async_reset();
        hand = 4'b0110;
        go1 = 1'b1;
        go2 = 1'b1;
        repeat (SHOW_AT + 3) tick();
        checks++;
        if (disp !== 1'b0) begin
            failures++;
            $display("FAIL areset_pre disp got=%b want=0", disp);
        end
        rst_n = 1'b0;
        go1 = 1'b0;
        go2 = 1'b0;
        #2;
        checks++;
        if (sseg !== 8'hFF || an !== 4'b1111 || disp !== 1'b1) begin
            failures++;
            $display("FAIL areset_reveal sseg/an/disp got=%h/%b/%b want=ff/1111/1", sseg, an, disp);
        end
        #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            checks++;
            if (disp !== 1'b1 || sseg !== S_BLANK || an !== exp_an()) begin
                failures++;
                $display("FAIL areset_after t=%0d sseg/an/disp got=%h/%b/%b want=ff/%b/1",
                         t, sseg, an, disp, exp_an());
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_reveal();
        test_invalid();
        test_one_button_release();
`ifdef RPS_WINNER_EN
        test_winner();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
